maze_move_ctrl: RTL
===================

Name: maze_move_ctrl

Overview:
- Sequences player moves for the maze game.
- Accepts one direction command per press on user_input, reads the wall bits of the current cell from the maze ROM, and decides whether the move is legal.
- Updates the player position, move counter and win flag.
- Sits between the input pins of the tt_um top and the maze ROM and display logic.

Parameters:
- X_BITS, 3, width of pos_x; grid is 2^X_BITS columns.
- Y_BITS, 3, width of pos_y; grid is 2^Y_BITS rows; y=0 is the top row.
- START_X, 0, reset/restart column.
- START_Y, 0, reset/restart row.
- GOAL_X, 7, goal column.
- GOAL_Y, 7, goal row.
- CNT_W, 8, move counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- ena  in  1  design enable; low freezes the block.
- user_input  in  3  command: 000 idle, 001 up, 010 down, 011 left, 100 right, 101 restart; 110/111 ignored.
- rom_rd  out  1  ROM read strobe.
- rom_addr  out  X_BITS+Y_BITS  cell address {pos_y,pos_x}.
- rom_data  in  4  wall bits of the addressed cell, valid the cycle after rom_rd: [0] up, [1] right, [2] down, [3] left; 1 = wall.
- pos_x  out  X_BITS  player column.
- pos_y  out  Y_BITS  player row.
- move_count  out  CNT_W  successful moves since restart.
- busy  out  1  move in flight (state FETCH or WAIT).
- bump  out  1  one-cycle pulse on a blocked move.
- won  out  1  goal reached; held until restart or reset.

Behaviour:
- Reset values (asynchronous, immediate, any state including mid-move):
  - state = IDLE, pos = (START_X, START_Y), move_count = 0.
  - won, bump, busy and rom_rd = 0.
  - Edge register prev_in = 000; rom_addr = {START_Y, START_X}.
- Command detect: cmd_evt = (prev_in == 000) && (user_input != 000).
  - prev_in <= user_input on every enabled clock, in all states.
  - A held command fires exactly once.
  - A press that occurs while busy is dropped and does not fire later.
- States:
  - IDLE: on cmd_evt with a direction code, latch the direction and go to FETCH. On cmd_evt with 101, restart (see below). Codes 110/111 produce no action.
  - FETCH: rom_rd = 1, rom_addr = {pos_y,pos_x}; go to WAIT.
  - WAIT: sample rom_data and compute blocked = wall bit for the direction OR grid border (up at y=0, down at y=max, left at x=0, right at x=max).
    - If blocked: pos and count unchanged, bump = 1 for the next cycle, go to IDLE.
    - Else: pos steps by 1 and move_count increments, saturating at 2^CNT_W-1. Go to WIN if the new pos equals (GOAL_X, GOAL_Y), otherwise IDLE.
  - WIN: won = 1. Direction commands are ignored; only 101 is accepted.
- Restart (101 accepted in IDLE or WIN):
  - At the accepting edge, pos = start, move_count = 0, won = 0, state = IDLE.
  - No ROM access.
- Latency: command sampled at edge E0 (IDLE to FETCH). rom_rd is high E0 to E1. Result is registered at E2: pos, count, won and bump visible after E2. busy is high E0 to E2.
- Maximum rate: one move per 3 cycles of press/release.
- rom_addr tracks {pos_y,pos_x} in all states. rom_rd is asserted only in FETCH, and only while ena = 1.
- ena = 0 holds all registers including prev_in and state.
  - FETCH with ena low deasserts rom_rd; the read is reissued when ena returns high.
  - WAIT does not advance while ena = 0; the bench must not drop ena during WAIT with a ROM lacking held output.
- A border block still performs the ROM read so latency is uniform.
- bump never coincides with a pos change.

Test Plan:
1. Reset with user_input = 000:
   - pos = (0,0), move_count = 0, won = 0, busy = 0, rom_rd = 0, rom_addr = 0.
   - Assert rst_n low mid-WAIT: all outputs return to reset values immediately, without a clock.
2. Open cell 0 (rom_data = 0000), user_input 000 to 100:
   - rom_rd = 1 for one cycle with rom_addr = 0.
   - After E2: pos_x = 1, move_count = 1, bump = 0.
   - Hold 100 for 10 more cycles: no further move.
3. Cell 1 returns 0010, press 100 at (1,0):
   - pos stays at (1,0), move_count stays 1.
   - bump is high exactly one cycle after E2.
4. At (0,0), press 001 (up) with rom_data = 0000: border block, bump pulse, pos unchanged. Press 011 (left): same result.
5. GOAL_X = 1, GOAL_Y = 0 override, open ROM, press 100:
   - won = 1 after E2.
   - A following 010 press produces no rom_rd and no change.
   - 101: pos = (0,0), count = 0, won = 0.
6. CNT_W = 2 override, alternate right/left moves 5 times on an open ROM: move_count saturates at 3. Press 110: no action and no rom_rd.

Source files
------------

// File: rtl/maze_move_ctrl.sv
// Player-move sequencer: one wall lookup in the maze ROM per direction press, then a position/count update.
// Latency: command edge E0 -> ROM read E0..E1 -> result registered at E2 (3 cycles per move).
// Backpressure: presses during a move in flight are dropped; after a win only restart is accepted; ena=0 freezes all state.
module maze_move_ctrl #(
  parameter int X_BITS  = 3,
  parameter int Y_BITS  = 3,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int GOAL_X  = 7,
  parameter int GOAL_Y  = 7,
  parameter int CNT_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [2:0]               user_input,
  output logic                     rom_rd,
  output logic [X_BITS+Y_BITS-1:0] rom_addr,
  input  logic [3:0]               rom_data,
  output logic [X_BITS-1:0]        pos_x,
  output logic [Y_BITS-1:0]        pos_y,
  output logic [CNT_W-1:0]         move_count,
  output logic                     busy,
  output logic                     bump,
  output logic                     won
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_WIN} state_t;

  localparam logic [2:0] C_UP      = 3'd1;
  localparam logic [2:0] C_DOWN    = 3'd2;
  localparam logic [2:0] C_LEFT    = 3'd3;
  localparam logic [2:0] C_RIGHT   = 3'd4;
  localparam logic [2:0] C_RESTART = 3'd5;

  localparam logic [X_BITS-1:0] SX    = X_BITS'(START_X);
  localparam logic [Y_BITS-1:0] SY    = Y_BITS'(START_Y);
  localparam logic [X_BITS-1:0] GX    = X_BITS'(GOAL_X);
  localparam logic [Y_BITS-1:0] GY    = Y_BITS'(GOAL_Y);
  localparam logic [X_BITS-1:0] X_ONE = X_BITS'(1);
  localparam logic [Y_BITS-1:0] Y_ONE = Y_BITS'(1);
  localparam logic [X_BITS-1:0] X_MAX = '1;
  localparam logic [Y_BITS-1:0] Y_MAX = '1;
  localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0]  C_MAX = '1;

  state_t            state_q, state_d;
  logic [2:0]        prev_in_q, prev_in_d;
  logic [2:0]        dir_q, dir_d;
  logic [X_BITS-1:0] pos_x_q, pos_x_d;
  logic [Y_BITS-1:0] pos_y_q, pos_y_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              bump_q, bump_d;

  logic              cmd_evt;
  logic              blocked;
  logic [X_BITS-1:0] step_x;
  logic [Y_BITS-1:0] step_y;

  // State registers; ena low freezes everything, including the press-edge history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      prev_in_q <= 3'b000;
      dir_q     <= 3'b000;
      pos_x_q   <= SX;
      pos_y_q   <= SY;
      cnt_q     <= '0;
      bump_q    <= 1'b0;
    end else if (ena) begin
      state_q   <= state_d;
      prev_in_q <= prev_in_d;
      dir_q     <= dir_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      cnt_q     <= cnt_d;
      bump_q    <= bump_d;
    end
  end

  // Candidate step and legality for the latched direction; border counts as a wall.
  always_comb begin
    blocked = 1'b0;
    step_x  = pos_x_q;
    step_y  = pos_y_q;
    case (dir_q)
      C_UP: begin
        blocked = rom_data[0] || (pos_y_q == '0);
        step_y  = pos_y_q - Y_ONE;
      end
      C_RIGHT: begin
        blocked = rom_data[1] || (pos_x_q == X_MAX);
        step_x  = pos_x_q + X_ONE;
      end
      C_DOWN: begin
        blocked = rom_data[2] || (pos_y_q == Y_MAX);
        step_y  = pos_y_q + Y_ONE;
      end
      C_LEFT: begin
        blocked = rom_data[3] || (pos_x_q == '0);
        step_x  = pos_x_q - X_ONE;
      end
      default: blocked = 1'b1;
    endcase
  end

  // Move sequencing: edge-detect the command, fetch walls, then commit or bump.
  always_comb begin
    state_d   = state_q;
    prev_in_d = user_input;
    dir_d     = dir_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    cnt_d     = cnt_q;
    bump_d    = 1'b0;
    cmd_evt   = (prev_in_q == 3'b000) && (user_input != 3'b000);
    case (state_q)
      S_IDLE: begin
        if (cmd_evt) begin
          if (user_input == C_UP || user_input == C_DOWN ||
              user_input == C_LEFT || user_input == C_RIGHT) begin
            dir_d   = user_input;
            state_d = S_FETCH;
          end else if (user_input == C_RESTART) begin
            pos_x_d = SX;
            pos_y_d = SY;
            cnt_d   = '0;
          end
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (blocked) begin
          bump_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          pos_x_d = step_x;
          pos_y_d = step_y;
          cnt_d   = (cnt_q == C_MAX) ? cnt_q : cnt_q + C_ONE;
          state_d = (step_x == GX && step_y == GY) ? S_WIN : S_IDLE;
        end
      end
      S_WIN: begin
        if (cmd_evt && user_input == C_RESTART) begin
          pos_x_d = SX;
          pos_y_d = SY;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rom_rd     = (state_q == S_FETCH) && ena;
  assign rom_addr   = {pos_y_q, pos_x_q};
  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign move_count = cnt_q;
  assign busy       = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign bump       = bump_q;
  assign won        = (state_q == S_WIN);

endmodule
